// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//
// Purpose:
//   Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock. Exposes
//   the active-area pixel coordinate to the picture stage, takes back its
//   combinational RGB565 value and re-registers it alongside hsync/vsync, so
//   every panel-facing output changes on the same clock edge.
//
//   Line and frame order: sync pulse, back porch, active area, front porch.
//
// Optional build macro:
//   VGA_BORDER_EN - when defined, the outermost ring of the active area is
//                   forced to white (16'hFFFF) as a monitor-alignment aid.
//                   Timing and every other output are unchanged.
//
// Ports:
//   vga_clk     in   1   pixel clock (only clock)
//   sys_rst     in   1   synchronous active-high reset
//   pix_data    in  16   RGB565 from the picture stage, combinational in pix_x/pix_y
//   pix_x       out 10   active column 0..H_DISP-1, 10'h3FF outside active area
//   pix_y       out 10   active row    0..V_DISP-1, 10'h3FF outside active area
//   hsync       out  1   registered, high during the horizontal sync pulse
//   vsync       out  1   registered, high during the vertical sync pulse
//   rgb         out 16   registered pixel to the DAC, 0 during blanking
//   frame_done  out  1   registered one-cycle pulse after the last frame clock
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_done
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_HI   = 10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] V_ACT_LO   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_HI   = 10'(V_SYNC + V_BACK + V_DISP - 1);
`ifdef VGA_BORDER_EN
  localparam logic [9:0] X_LAST     = 10'(H_DISP - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_DISP - 1);
`endif

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_hsync;
  logic        r_vsync;
  logic [15:0] r_rgb;
  logic        r_frame_done;

  logic        w_h_act;
  logic        w_v_act;
  logic        w_act;
  logic        w_h_end;
  logic        w_v_end;
  logic        w_border;
  logic [9:0]  w_pix_x;
  logic [9:0]  w_pix_y;
  logic [15:0] w_rgb_nxt;

  // Coordinate decode; the subtraction only ever reaches the ports inside
  // the active window, so it cannot underflow onto pix_x/pix_y.
  always_comb begin
    w_h_act = (r_h_cnt >= H_ACT_LO) && (r_h_cnt <= H_ACT_HI);
    w_v_act = (r_v_cnt >= V_ACT_LO) && (r_v_cnt <= V_ACT_HI);
    w_act   = w_h_act && w_v_act;
    w_h_end = (r_h_cnt == H_LAST);
    w_v_end = (r_v_cnt == V_LAST);
    w_pix_x = '1;
    w_pix_y = '1;
    if (w_act) begin
      w_pix_x = r_h_cnt - H_ACT_LO;
      w_pix_y = r_v_cnt - V_ACT_LO;
    end
  end

  always_comb begin
`ifdef VGA_BORDER_EN
    w_border = w_act && ((w_pix_x == '0) || (w_pix_x == X_LAST) ||
                         (w_pix_y == '0) || (w_pix_y == Y_LAST));
`else
    w_border = 1'b0;
`endif
    w_rgb_nxt = '0;
    if (w_act) begin
      w_rgb_nxt = w_border ? '1 : pix_data;
    end
  end

  // Counters and output registers share one clock edge so that the counter
  // state at cycle N shows up on hsync/vsync/rgb/frame_done at N+1.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_rgb        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_h_end) begin
        r_h_cnt <= '0;
        if (w_v_end) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 10'd1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
      r_hsync      <= (r_h_cnt < H_SYNC_END);
      r_vsync      <= (r_v_cnt < V_SYNC_END);
      r_rgb        <= w_rgb_nxt;
      r_frame_done <= w_h_end && w_v_end;
    end
  end

  assign pix_x      = w_pix_x;
  assign pix_y      = w_pix_y;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign rgb        = r_rgb;
  assign frame_done = r_frame_done;

endmodule
